iq_tx_modulator: RTL and testbench
==================================

IQ_TX_MODULATOR -- requirements
Module: iq_tx_modulator

Interface
REQ-001 Parameter BITS, default 16, width of I/Q samples and of NCO sin/cos words (two's complement).
REQ-002 Parameter INTERP, default 64, CLK cycles each I/Q sample is held; legal range 2..65535.
REQ-003 CLK  input  1  sole clock; all logic on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 I_in  input  BITS  signed baseband in-phase sample.
REQ-006 Q_in  input  BITS  signed baseband quadrature sample.
REQ-007 IQ_valid  input  1  I_in/Q_in hold a valid sample.
REQ-008 IQ_ready  output  1  block can accept a sample this cycle.
REQ-009 sin_in  input  BITS  signed NCO sine, one word per CLK.
REQ-010 cos_in  input  BITS  signed NCO cosine, one word per CLK.
REQ-011 RF_out  output  1  registered 1-bit sigma-delta RF bitstream.
REQ-012 UNDERRUN  output  1  one-cycle pulse when a hold period ends with no sample available.

Function
REQ-013 Transfer occurs on an edge where IQ_valid and IQ_ready are both 1; IQ_ready = NOT pending_full (registered state, no combinational path from IQ_valid).
REQ-014 One-entry pending buffer plus active I/Q register; transfer writes pending, except when a load event coincides with an empty pending buffer, where the transferred sample goes directly to active (bypass, no underrun).
REQ-015 Hold counter counts INTERP-1 down to 0 and reloads; a load event is the cycle the counter is 0.
REQ-016 On load event: pending full -> pending to active, pending cleared; pending empty and no transfer -> active set to 0, UNDERRUN pulsed for that cycle.
REQ-017 Pipeline: sin/cos registered every cycle (stage 1); products I*cos and Q*sin, 2*BITS wide signed, registered (stage 2); y = (I*cos - Q*sin) >>> (BITS-1), BITS+1 signed, arithmetic shift, registered (stage 3); modulator update and RF_out (stage 4).
REQ-018 Latency: RF_out at edge n+3 reflects sin_in/cos_in sampled at edge n and the active I/Q held at edge n.
REQ-019 First-order modulator: RF_out = 1 when acc >= 0 else 0; fb = +2^BITS if RF_out else -2^BITS; acc_next = acc + y - fb; acc width BITS+3 signed, no wrap for |y| <= 2^BITS.
REQ-020 No-sample state: active I/Q of 0 gives y = 0; RF_out toggles 1,0,1,0 (50% density).
REQ-021 Pending full and IQ_valid held: IQ_ready stays 0, sample not lost, accepted the cycle after the next load event.

Reset
REQ-022 RST asserted at an edge, including mid-sample or mid-pending: RF_out=0, UNDERRUN=0, IQ_ready=1, pending cleared, active I/Q=0, all pipeline registers and accumulators=0, hold counter=INTERP-1.
REQ-023 First load event occurs INTERP cycles after RST deasserts; RST dominates any simultaneous transfer.

Configuration
REQ-024 Macro IQ_TX_SDM2_EN defined: second-order loop, acc1_next = acc1 + y - fb, acc2_next = acc2 + acc1 - fb, RF_out = (acc2 >= 0), both accumulators BITS+6 signed, saturating at limits.
REQ-025 Macro IQ_TX_SDM2_EN undefined: first-order loop of REQ-019 only; interface and latency identical in both builds.

Structure
REQ-026 Package iq_tx_pkg holds the accumulator-width and feedback-magnitude constant functions of BITS and the default INTERP.
REQ-027 Sub-module sdm_core implements stage 4 (accumulators, comparator, feedback, IQ_TX_SDM2_EN selection); iq_tx_modulator holds handshake, hold counter, pipeline.

Verification
REQ-028 Reset, IQ_valid=0, cos=32767, sin=0 -> RF_out 1,0,1,0 from stage-4 output onward; UNDERRUN pulses every 64 cycles.
REQ-029 First-order build, I=16384, Q=0, cos=32767, sin=0 constant, samples always supplied -> y=16383; 640 +/- 1 ones in 1024 consecutive RF_out bits.
REQ-030 IQ_valid held high with new sample every cycle -> exactly one transfer per 64 cycles after the first, IQ_ready 0 between, no UNDERRUN, samples reach active in order.
REQ-031 Supply one sample, then stop -> sample active for 64 cycles, next load sets active to 0 and UNDERRUN=1 for one cycle.
REQ-032 Transfer on the load-event cycle with pending empty -> sample becomes active that edge, no UNDERRUN.
REQ-033 RST for one cycle mid-hold with pending full -> all outputs at reset values next cycle, IQ_ready=1, RF_out resumes 1,0 alternation.

Source files
------------

// File: rtl/iq_tx_pkg.sv
// iq_tx_pkg: shared constants and helpers for the IQ transmit modulator.
//   DEFAULT_INTERP  - default number of CLK cycles each I/Q sample is held
//   CNT_W           - width of the hold counter (INTERP up to 65535)
//   pend_state_t    - occupancy of the one-entry pending sample buffer
//   sdm1_acc_w()    - first-order accumulator width for a given BITS
//   sdm2_acc_w()    - second-order accumulator width for a given BITS
//   fb_mag()        - sigma-delta feedback magnitude (2^BITS)
package iq_tx_pkg;

  localparam int unsigned DEFAULT_INTERP = 64;
  localparam int unsigned CNT_W          = 16;

  typedef enum logic {
    PEND_EMPTY = 1'b0,
    PEND_FULL  = 1'b1
  } pend_state_t;

  function automatic int unsigned sdm1_acc_w(input int unsigned bits);
    return bits + 3;
  endfunction

  function automatic int unsigned sdm2_acc_w(input int unsigned bits);
    return bits + 6;
  endfunction

  function automatic longint fb_mag(input int unsigned bits);
    return longint'(1) << bits;
  endfunction

endpackage

// File: rtl/iq_tx_modulator_sdm_core.sv
// sdm_core: final pipeline stage of the IQ transmit modulator. Integrates the
// mixed baseband value y and produces the registered 1-bit RF bitstream.
// Build option: define IQ_TX_SDM2_EN for a saturating second-order loop;
// otherwise a first-order loop is built. Latency is identical in both.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   synchronous active-high reset
//   y      in   BITS+1 signed mixed sample (stage-3 output)
//   rf_out out  registered 1-bit sigma-delta output
module sdm_core
  import iq_tx_pkg::*;
#(
  parameter int unsigned BITS = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic signed [BITS:0] y,
  output logic               rf_out
);

  logic rf_next;

`ifdef IQ_TX_SDM2_EN
  localparam int unsigned ACC_W = sdm2_acc_w(BITS);
  // Two guard bits so the un-saturated sums never wrap before clamping.
  localparam int unsigned EXT_W = ACC_W + 2;
  localparam logic signed [EXT_W-1:0] FB      = EXT_W'(fb_mag(BITS));
  localparam logic signed [EXT_W-1:0] ACC_MAX = EXT_W'((longint'(1) << (ACC_W - 1)) - 1);
  localparam logic signed [EXT_W-1:0] ACC_MIN = EXT_W'(-(longint'(1) << (ACC_W - 1)));

  logic signed [ACC_W-1:0] acc1, acc2;
  logic signed [EXT_W-1:0] v1, v2, n1, n2;

  function automatic logic signed [ACC_W-1:0] sat(input logic signed [EXT_W-1:0] x);
    if (x > ACC_MAX)      return ACC_W'(ACC_MAX);
    else if (x < ACC_MIN) return ACC_W'(ACC_MIN);
    else                  return ACC_W'(x);
  endfunction

  // The comparator looks at the integrator value including the new y, so
  // RF_out reflects y on the same edge the accumulators absorb it.
  always_comb begin
    v1      = EXT_W'(acc1) + EXT_W'(y);
    v2      = EXT_W'(acc2) + v1;
    rf_next = !v2[EXT_W-1];
    n1      = v1 - (rf_next ? FB : -FB);
    n2      = v2 - (rf_next ? FB : -FB);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc1 <= '0;
      acc2 <= '0;
    end else begin
      acc1 <= sat(n1);
      acc2 <= sat(n2);
    end
  end
`else
  localparam int unsigned ACC_W = sdm1_acc_w(BITS);
  localparam logic signed [ACC_W-1:0] FB = ACC_W'(fb_mag(BITS));

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] v;

  // With |y| <= 2^BITS the integrator stays within +/-2^(BITS+1), so no
  // wrap handling is needed at BITS+3 bits.
  always_comb begin
    v       = acc + ACC_W'(y);
    rf_next = !v[ACC_W-1];
  end

  always_ff @(posedge clk) begin
    if (rst) acc <= '0;
    else     acc <= v - (rf_next ? FB : -FB);
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) rf_out <= 1'b0;
    else     rf_out <= rf_next;
  end

endmodule

// File: rtl/iq_tx_modulator.sv
// iq_tx_modulator: accepts baseband I/Q samples through a valid/ready
// handshake, holds each for INTERP clocks, mixes with an external NCO and
// drives a 1-bit sigma-delta RF bitstream.
// Build option: IQ_TX_SDM2_EN selects the second-order loop in sdm_core.
// Parameters: BITS (sample/NCO width), INTERP (hold length, 2..65535).
// Ports:
//   CLK       in   clock, rising edge
//   RST       in   synchronous active-high reset
//   I_in      in   BITS signed in-phase sample
//   Q_in      in   BITS signed quadrature sample
//   IQ_valid  in   I_in/Q_in valid
//   IQ_ready  out  sample can be accepted (pending buffer empty)
//   sin_in    in   BITS signed NCO sine
//   cos_in    in   BITS signed NCO cosine
//   RF_out    out  registered sigma-delta bitstream
//   UNDERRUN  out  one-cycle pulse: hold period ended with no sample
module iq_tx_modulator
  import iq_tx_pkg::*;
#(
  parameter int unsigned BITS   = 16,
  parameter int unsigned INTERP = DEFAULT_INTERP
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic signed [BITS-1:0] I_in,
  input  logic signed [BITS-1:0] Q_in,
  input  logic                   IQ_valid,
  output logic                   IQ_ready,
  input  logic signed [BITS-1:0] sin_in,
  input  logic signed [BITS-1:0] cos_in,
  output logic                   RF_out,
  output logic                   UNDERRUN
);

  localparam int unsigned PROD_W = 2 * BITS;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(INTERP - 1);

  pend_state_t pend_state, pend_next;

  logic [CNT_W-1:0]       hold_cnt;
  logic                   load;
  logic                   transfer;
  logic signed [BITS-1:0] pend_i, pend_q;
  logic signed [BITS-1:0] act_i, act_q;

  logic signed [BITS-1:0]   cos_s1, sin_s1, i_s1, q_s1;
  logic signed [PROD_W-1:0] prod_i, prod_q;
  logic signed [PROD_W:0]   diff;
  logic signed [BITS:0]     y_s3;

  // Ready comes straight from registered state, never from IQ_valid.
  assign IQ_ready = (pend_state == PEND_EMPTY);
  assign transfer = IQ_valid && IQ_ready;
  assign load     = (hold_cnt == '0);

  // Pending buffer occupancy. A transfer on a load cycle bypasses the
  // buffer, so it only fills on transfers away from load events.
  always_comb begin
    pend_next = pend_state;
    case (pend_state)
      PEND_EMPTY: if (transfer && !load) pend_next = PEND_FULL;
      PEND_FULL:  if (load)              pend_next = PEND_EMPTY;
      default:                           pend_next = PEND_EMPTY;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) pend_state <= PEND_EMPTY;
    else     pend_state <= pend_next;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt <= RELOAD;
      pend_i   <= '0;
      pend_q   <= '0;
      act_i    <= '0;
      act_q    <= '0;
      UNDERRUN <= 1'b0;
    end else begin
      hold_cnt <= load ? RELOAD : hold_cnt - 1'b1;
      UNDERRUN <= load && (pend_state == PEND_EMPTY) && !transfer;
      if (transfer && !load) begin
        pend_i <= I_in;
        pend_q <= Q_in;
      end
      if (load) begin
        if (pend_state == PEND_FULL) begin
          act_i <= pend_i;
          act_q <= pend_q;
        end else if (transfer) begin
          act_i <= I_in;
          act_q <= Q_in;
        end else begin
          act_i <= '0;
          act_q <= '0;
        end
      end
    end
  end

  // Stage 1 captures the active sample alongside the NCO words so that both
  // travel down the pipeline together.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cos_s1 <= '0;
      sin_s1 <= '0;
      i_s1   <= '0;
      q_s1   <= '0;
      prod_i <= '0;
      prod_q <= '0;
      y_s3   <= '0;
    end else begin
      cos_s1 <= cos_in;
      sin_s1 <= sin_in;
      i_s1   <= act_i;
      q_s1   <= act_q;
      prod_i <= PROD_W'(i_s1) * PROD_W'(cos_s1);
      prod_q <= PROD_W'(q_s1) * PROD_W'(sin_s1);
      y_s3   <= (BITS + 1)'(diff >>> (BITS - 1));
    end
  end

  always_comb begin
    diff = (PROD_W + 1)'(prod_i) - (PROD_W + 1)'(prod_q);
  end

  sdm_core #(
    .BITS(BITS)
  ) u_sdm_core (
    .clk    (CLK),
    .rst    (RST),
    .y      (y_s3),
    .rf_out (RF_out)
  );

endmodule

// File: tb/tb_iq_tx_modulator.sv
// Self-checking bench for iq_tx_modulator (default first-order build).
module tb_iq_tx_modulator;

  localparam int unsigned BITS   = 16;
  localparam int unsigned INTERP = 64;
  localparam longint      FBM    = 65536;

  logic                   CLK = 1'b0;
  logic                   RST = 1'b1;
  logic signed [BITS-1:0] I_in = '0;
  logic signed [BITS-1:0] Q_in = '0;
  logic                   IQ_valid = 1'b0;
  logic                   IQ_ready;
  logic signed [BITS-1:0] sin_in = '0;
  logic signed [BITS-1:0] cos_in = '0;
  logic                   RF_out;
  logic                   UNDERRUN;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  iq_tx_modulator #(
    .BITS   (BITS),
    .INTERP (INTERP)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .I_in     (I_in),
    .Q_in     (Q_in),
    .IQ_valid (IQ_valid),
    .IQ_ready (IQ_ready),
    .sin_in   (sin_in),
    .cos_in   (cos_in),
    .RF_out   (RF_out),
    .UNDERRUN (UNDERRUN)
  );

  always #5 CLK = ~CLK;

  // Reference model: elapsed-time schedule for hold periods, a size<=1 queue
  // for the pending sample, a 3-deep delay line for the mixed value and an
  // integer sigma-delta integrator.
  longint  m_t;
  longint  m_acc;
  int      m_ai, m_aq;
  int      pq_i[$], pq_q[$];
  longint  ydl[$];
  longint  m_y, m_v;
  bit      m_load, m_xfer;
  bit      e_rf, e_und;

  always @(posedge CLK) begin
    if (RST) begin
      m_t = 0; m_acc = 0; m_ai = 0; m_aq = 0;
      pq_i.delete(); pq_q.delete();
      ydl = '{0, 0, 0};
      e_rf = 1'b0; e_und = 1'b0;
    end else begin
      m_y = (longint'(m_ai) * longint'(cos_in) - longint'(m_aq) * longint'(sin_in)) >>> (BITS - 1);
      ydl.push_back(m_y);
      m_v   = m_acc + ydl.pop_front();
      e_rf  = (m_v >= 0);
      m_acc = m_v - (e_rf ? FBM : -FBM);
      m_load = ((m_t % INTERP) == INTERP - 1);
      m_t++;
      m_xfer = IQ_valid && (pq_i.size() == 0);
      e_und  = 1'b0;
      if (m_load) begin
        if (pq_i.size() != 0) begin
          m_ai = pq_i.pop_front();
          m_aq = pq_q.pop_front();
        end else if (m_xfer) begin
          m_ai = int'(I_in);
          m_aq = int'(Q_in);
        end else begin
          m_ai = 0; m_aq = 0; e_und = 1'b1;
        end
      end else if (m_xfer) begin
        pq_i.push_back(int'(I_in));
        pq_q.push_back(int'(Q_in));
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      tests += 3;
      if (RF_out !== e_rf) begin
        fails++;
        $display("FAIL model_rf t=%0t got %0b exp %0b", $time, RF_out, e_rf);
      end
      if (UNDERRUN !== e_und) begin
        fails++;
        $display("FAIL model_underrun t=%0t got %0b exp %0b", $time, UNDERRUN, e_und);
      end
      if (IQ_ready !== (pq_i.size() == 0)) begin
        fails++;
        $display("FAIL model_ready t=%0t got %0b exp %0b", $time, IQ_ready, pq_i.size() == 0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp, input longint tol);
    tests++;
    if (act < exp - tol || act > exp + tol) begin
      fails++;
      $display("FAIL %s got %0d exp %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  int und_cnt, ones, xfers, r;

  initial begin
    // Idle carrier: no samples, y = 0.
    IQ_valid = 1'b0; cos_in = 16'sd32767; sin_in = '0;
    RST = 1'b1;
    tick();
    tick();
    chk_en = 1'b1;
    check("reset_rf", RF_out, 0);
    check("reset_underrun", UNDERRUN, 0);
    check("reset_ready", IQ_ready, 1);
    RST = 1'b0;
    und_cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (k <= 4) check("idle_rf_alt", RF_out, k % 2);
      if (k == 63) check("idle_und_63", UNDERRUN, 0);
      if (k == 64) check("idle_und_64", UNDERRUN, 1);
      und_cnt += int'(UNDERRUN);
    end
    check("idle_und_count", und_cnt, 3);

    // Constant I=16384 supplied continuously: density and handshake rate.
    do_reset();
    IQ_valid = 1'b1; I_in = 16'sd16384; Q_in = '0;
    ones = 0; xfers = 0; und_cnt = 0;
    for (int k = 1; k <= 1400; k++) begin
      if (k > 300 && k <= 940 && IQ_ready) xfers++;
      if (k == 30) check("held_ready_low", IQ_ready, 0);
      tick();
      if (k > 300 && k <= 1324) ones += int'(RF_out);
      und_cnt += int'(UNDERRUN);
    end
    check_tol("density_ones", ones, 640, 1);
    check("xfers_per_640", xfers, 10);
    check("stream_no_underrun", und_cnt, 0);

    // One sample then nothing.
    do_reset();
    IQ_valid = 1'b1; I_in = 16'sd12000; Q_in = -16'sd5000;
    tick();
    IQ_valid = 1'b0;
    for (int k = 2; k <= 140; k++) begin
      tick();
      if (k == 64)  check("single_und_64", UNDERRUN, 0);
      if (k == 128) check("single_und_128", UNDERRUN, 1);
      if (k == 129) check("single_und_129", UNDERRUN, 0);
    end

    // Transfer exactly on the load cycle with pending empty: bypass.
    do_reset();
    IQ_valid = 1'b0;
    for (int k = 1; k <= 63; k++) tick();
    IQ_valid = 1'b1; I_in = -16'sd8000; Q_in = 16'sd3000;
    tick();
    check("bypass_no_und", UNDERRUN, 0);
    check("bypass_ready", IQ_ready, 1);
    IQ_valid = 1'b0;
    for (int k = 65; k <= 128; k++) tick();
    check("bypass_und_128", UNDERRUN, 1);

    // Random samples, handshake gaps and NCO words.
    do_reset();
    for (int k = 0; k < 700; k++) begin
      IQ_valid = ($urandom_range(0, 3) != 0);
      r = int'($urandom_range(0, 40000)) - 20000; I_in = BITS'(r);
      r = int'($urandom_range(0, 40000)) - 20000; Q_in = BITS'(r);
      r = int'($urandom_range(0, 65534)) - 32767; cos_in = BITS'(r);
      r = int'($urandom_range(0, 65534)) - 32767; sin_in = BITS'(r);
      tick();
    end

    // Reset mid-hold with the pending buffer full.
    cos_in = 16'sd32767; sin_in = '0;
    do_reset();
    IQ_valid = 1'b1; I_in = 16'sd9000; Q_in = 16'sd1000;
    for (int k = 0; k < 40; k++) tick();
    RST = 1'b1;
    tick();
    check("midreset_rf", RF_out, 0);
    check("midreset_und", UNDERRUN, 0);
    check("midreset_ready", IQ_ready, 1);
    RST = 1'b0; IQ_valid = 1'b0;
    tick();
    check("midreset_rf1", RF_out, 1);
    tick();
    check("midreset_rf0", RF_out, 0);
    tick();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
